// File: rtl/rvh_l1d_amo_ctrl.sv
// +----------------------------------------------------------------------------+
// | rvh_l1d_amo_ctrl : L1D AMO sequencer (read bank word, ALU op, write back)  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package uop_encoding_pkg;
  localparam int ALU_OP_WIDTH = 4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'd9;
endpackage

module rvh_l1d_amo_ctrl
  import uop_encoding_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int BANK_W = 128,
  parameter int ID_W   = 4,
  localparam int OFF_W = $clog2(BANK_W/8)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [3:0]              req_op_i,
  input  logic                    req_w_i,
  input  logic [OFF_W-1:0]        req_off_i,
  input  logic [XLEN-1:0]         req_rs2_i,
  input  logic [ID_W-1:0]         req_id_i,
  output logic                    rd_valid_o,
  input  logic                    rd_ready_i,
  input  logic                    rd_data_valid_i,
  input  logic [BANK_W-1:0]       rd_data_i,
  output logic [ALU_OP_WIDTH-1:0] alu_opcode_o,
  output logic                    alu_op_w_o,
  output logic [XLEN-1:0]         alu_operand0_o,
  output logic [XLEN-1:0]         alu_operand1_o,
  input  logic [XLEN-1:0]         alu_result_i,
  output logic                    wr_valid_o,
  input  logic                    wr_ready_i,
  output logic [BANK_W-1:0]       wr_data_o,
  output logic [BANK_W/8-1:0]     wr_be_o,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [ID_W-1:0]         resp_id_o,
  output logic [XLEN-1:0]         resp_data_o,
  output logic                    resp_err_o,
  output logic                    busy_o
);

  localparam int BE_W = BANK_W/8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_WR      = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  localparam logic [3:0] OP_SWAP = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_MIN  = 4'd5;
  localparam logic [3:0] OP_MAX  = 4'd6;
  localparam logic [3:0] OP_MINU = 4'd7;
  localparam logic [3:0] OP_MAXU = 4'd8;

  logic [2:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic             w_q, w_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [XLEN-1:0]  rs2x_q, rs2x_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             err_q, err_d;
  logic [XLEN-1:0]  old_q, old_d;
  logic [XLEN-1:0]  new_q, new_d;

  logic             req_misalign;
  logic [XLEN-1:0]  req_rs2x;
  logic [31:0]      rd_word32;
  logic [XLEN-1:0]  rd_word64;
  logic [XLEN-1:0]  exec_new;
  logic             exec_lt;
  logic [XLEN-1:0]  wr_lane;
  logic [BE_W-1:0]  be_base;

  assign req_misalign = req_w_i ? (req_off_i[1:0] != 2'b00) : (req_off_i[2:0] != 3'b000);
  assign req_rs2x     = req_w_i ? {{(XLEN-32){req_rs2_i[31]}}, req_rs2_i[31:0]} : req_rs2_i;

  // Indices built from the aligned offset bits so the selects never leave the bank word.
  assign rd_word32 = rd_data_i[{off_q[OFF_W-1:2], 5'b00000} +: 32];
  assign rd_word64 = rd_data_i[{off_q[OFF_W-1:3], 6'b000000} +: XLEN];

  always_comb begin
    alu_opcode_o   = ALU_ADD;
    alu_op_w_o     = 1'b0;
    alu_operand0_o = '0;
    alu_operand1_o = '0;
    if (state_q == S_EXEC) begin
      alu_operand0_o = old_q;
      alu_operand1_o = rs2x_q;
      case (op_q)
        OP_ADD: begin
          alu_opcode_o = ALU_ADD;
          alu_op_w_o   = w_q;
        end
        OP_XOR:           alu_opcode_o = ALU_XOR;
        OP_AND:           alu_opcode_o = ALU_AND;
        OP_OR:            alu_opcode_o = ALU_OR;
        OP_MIN, OP_MAX:   alu_opcode_o = ALU_SLT;
        OP_MINU, OP_MAXU: alu_opcode_o = ALU_SLTU;
        default:          alu_opcode_o = ALU_ADD;
      endcase
    end
  end

  assign exec_lt = alu_result_i[0];

  always_comb begin
    exec_new = rs2x_q;
    case (op_q)
      OP_ADD, OP_XOR, OP_AND, OP_OR: exec_new = alu_result_i;
      OP_MIN, OP_MINU:               exec_new = exec_lt ? old_q : rs2x_q;
      OP_MAX, OP_MAXU:               exec_new = exec_lt ? rs2x_q : old_q;
      default:                       exec_new = rs2x_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    w_d     = w_q;
    off_d   = off_q;
    rs2x_d  = rs2x_q;
    id_d    = id_q;
    err_d   = err_q;
    old_d   = old_q;
    new_d   = new_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          op_d    = (req_op_i > OP_MAXU) ? OP_SWAP : req_op_i;
          w_d     = req_w_i;
          off_d   = req_off_i;
          rs2x_d  = req_rs2x;
          id_d    = req_id_i;
          err_d   = req_misalign;
          state_d = req_misalign ? S_RESP : S_RD_REQ;
        end
      end
      S_RD_REQ:  if (rd_ready_i) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (rd_data_valid_i) begin
          old_d   = w_q ? {{(XLEN-32){rd_word32[31]}}, rd_word32} : rd_word64;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        new_d   = exec_new;
        state_d = S_WR;
      end
      S_WR:    if (wr_ready_i) state_d = S_RESP;
      S_RESP:  if (resp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      w_q     <= 1'b0;
      off_q   <= '0;
      rs2x_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      old_q   <= '0;
      new_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      w_q     <= w_d;
      off_q   <= off_d;
      rs2x_q  <= rs2x_d;
      id_q    <= id_d;
      err_q   <= err_d;
      old_q   <= old_d;
      new_q   <= new_d;
    end
  end

  assign wr_lane = w_q ? {{(XLEN-32){1'b0}}, new_q[31:0]} : new_q;
  assign be_base = w_q ? BE_W'(8'h0F) : BE_W'(8'hFF);

  assign req_ready_o  = (state_q == S_IDLE);
  assign rd_valid_o   = (state_q == S_RD_REQ);
  assign wr_valid_o   = (state_q == S_WR);
  assign wr_data_o    = (state_q == S_WR) ? ({{(BANK_W-XLEN){1'b0}}, wr_lane} << {off_q, 3'b000}) : '0;
  assign wr_be_o      = (state_q == S_WR) ? (be_base << off_q) : '0;
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_id_o    = (state_q == S_RESP) ? id_q : '0;
  assign resp_data_o  = (state_q == S_RESP && !err_q) ? old_q : '0;
  assign resp_err_o   = (state_q == S_RESP) && err_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rvh_l1d_amo_ctrl.sv
// Scoreboard bench for rvh_l1d_amo_ctrl: bench-side bank, ALU and byte-level AMO reference model.
`default_nettype none

module tb_rvh_l1d_amo_ctrl;
  import uop_encoding_pkg::*;

  localparam logic [127:0] INIT_MEM = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  be;
  } wr_exp_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic        err;
  } resp_exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic req_valid_i = 1'b0;
  logic req_ready_o;
  logic [3:0] req_op_i = '0;
  logic req_w_i = 1'b0;
  logic [3:0] req_off_i = '0;
  logic [63:0] req_rs2_i = '0;
  logic [3:0] req_id_i = '0;
  logic rd_valid_o;
  logic rd_ready_i = 1'b1;
  logic rd_data_valid_i = 1'b0;
  logic [127:0] rd_data_i = '0;
  logic [ALU_OP_WIDTH-1:0] alu_opcode_o;
  logic alu_op_w_o;
  logic [63:0] alu_operand0_o, alu_operand1_o, alu_result_i;
  logic wr_valid_o;
  logic wr_ready_i = 1'b1;
  logic [127:0] wr_data_o;
  logic [15:0] wr_be_o;
  logic resp_valid_o;
  logic resp_ready_i = 1'b1;
  logic [3:0] resp_id_o;
  logic [63:0] resp_data_o;
  logic resp_err_o;
  logic busy_o;

  rvh_l1d_amo_ctrl dut (
    .clk(clk), .rstn(rstn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_w_i(req_w_i), .req_off_i(req_off_i), .req_rs2_i(req_rs2_i), .req_id_i(req_id_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_valid_i(rd_data_valid_i),
    .rd_data_i(rd_data_i),
    .alu_opcode_o(alu_opcode_o), .alu_op_w_o(alu_op_w_o), .alu_operand0_o(alu_operand0_o),
    .alu_operand1_o(alu_operand1_o), .alu_result_i(alu_result_i),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_data_o(wr_data_o), .wr_be_o(wr_be_o),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_id_o(resp_id_o),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  wr_exp_t   wr_q[$];
  resp_exp_t resp_q[$];
  logic      rd_q[$];

  logic [127:0] ref_mem = INIT_MEM;
  logic [127:0] bank_mem;
  logic fast = 1'b1;
  int rd_delay_force = 0;
  int resp_cyc = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] alu_model(input logic [3:0] opc, input logic opw,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [63:0] s;
    s = a + b;
    case (opc)
      ALU_ADD:  alu_model = opw ? {{32{s[31]}}, s[31:0]} : s;
      ALU_SLT:  alu_model = {63'd0, $signed(a) < $signed(b)};
      ALU_SLTU: alu_model = {63'd0, a < b};
      ALU_XOR:  alu_model = a ^ b;
      ALU_OR:   alu_model = a | b;
      ALU_AND:  alu_model = a & b;
      default:  alu_model = 64'd0;
    endcase
  endfunction

  always_comb alu_result_i = alu_model(alu_opcode_o, alu_op_w_o, alu_operand0_o, alu_operand1_o);

  // Bank: readies, read-data return (with junk data and spurious valids when idle) and writes.
  initial begin : bank
    logic rd_hs, wr_hs;
    logic [127:0] wd;
    logic [15:0] wb;
    int rd_cnt;
    bank_mem = INIT_MEM;
    rd_cnt = 0;
    forever begin
      @(negedge clk);
      rd_hs = rstn && rd_valid_o && rd_ready_i;
      wr_hs = rstn && wr_valid_o && wr_ready_i;
      wd = wr_data_o;
      wb = wr_be_o;
      @(posedge clk);
      if (wr_hs)
        for (int i = 0; i < 16; i++) if (wb[i]) bank_mem[8*i +: 8] = wd[8*i +: 8];
      #1;
      if (rd_hs) rd_cnt = (rd_delay_force > 0) ? rd_delay_force : (fast ? 1 : int'($urandom_range(1, 3)));
      rd_data_valid_i = 1'b0;
      rd_data_i = {$urandom, $urandom, $urandom, $urandom};
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          rd_data_valid_i = 1'b1;
          rd_data_i = bank_mem;
        end
      end else if (!fast && (wr_valid_o || resp_valid_o) && ($urandom % 4 == 0)) begin
        rd_data_valid_i = 1'b1;
      end
      rd_ready_i   = fast ? 1'b1 : ($urandom_range(0, 9) < 6);
      wr_ready_i   = fast ? 1'b1 : ($urandom_range(0, 9) < 6);
      resp_ready_i = fast ? 1'b1 : ($urandom_range(0, 9) < 6);
    end
  end

  // Monitor: pops expectations on handshakes and checks stall stability.
  initial begin : monitor
    logic st_rd, st_wr, st_resp;
    logic [127:0] h_wd;
    logic [15:0] h_be;
    logic [3:0] h_id;
    logic [63:0] h_rd;
    logic h_err;
    wr_exp_t we;
    resp_exp_t re;
    st_rd = 0; st_wr = 0; st_resp = 0;
    h_wd = '0; h_be = '0; h_id = '0; h_rd = '0; h_err = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        st_rd = 0; st_wr = 0; st_resp = 0;
      end else begin
        if (st_rd) check("rd_valid_hold", rd_valid_o, 1'b1);
        if (st_wr) check("wr_hold", {wr_valid_o, wr_be_o, wr_data_o}, {1'b1, h_be, h_wd});
        if (st_resp)
          check("resp_hold", {resp_valid_o, resp_id_o, resp_data_o, resp_err_o},
                {1'b1, h_id, h_rd, h_err});
        if (rd_valid_o && rd_ready_i) begin
          check("rd_expected", rd_q.size() > 0, 1'b1);
          if (rd_q.size() > 0) void'(rd_q.pop_front());
        end
        if (wr_valid_o && wr_ready_i) begin
          check("wr_expected", wr_q.size() > 0, 1'b1);
          if (wr_q.size() > 0) begin
            we = wr_q.pop_front();
            check("wr_data", wr_data_o, we.data);
            check("wr_be", wr_be_o, we.be);
          end
        end
        if (resp_valid_o && resp_ready_i) begin
          check("resp_expected", resp_q.size() > 0, 1'b1);
          if (resp_q.size() > 0) begin
            re = resp_q.pop_front();
            check("resp_id", resp_id_o, re.id);
            check("resp_data", resp_data_o, re.data);
            check("resp_err", resp_err_o, re.err);
          end
          resp_cyc = cyc + 1;
        end
        st_rd = rd_valid_o && !rd_ready_i;
        st_wr = wr_valid_o && !wr_ready_i;
        st_resp = resp_valid_o && !resp_ready_i;
        h_wd = wr_data_o; h_be = wr_be_o;
        h_id = resp_id_o; h_rd = resp_data_o; h_err = resp_err_o;
      end
    end
  end

  // Reference: byte-addressed read-modify-write of the bank word.
  task automatic do_amo(input logic [3:0] op, input logic w, input logic [3:0] off,
                        input logic [63:0] rs2, input logic [3:0] id);
    int nb;
    logic err;
    logic [63:0] oldv, b, newv, s;
    wr_exp_t we;
    resp_exp_t re;
    int req_cyc;
    bit done;
    nb = w ? 4 : 8;
    err = (off % nb) != 0;
    oldv = '0;
    newv = '0;
    if (!err) begin
      for (int i = 0; i < nb; i++) oldv[8*i +: 8] = ref_mem[8*(off+i) +: 8];
      if (w) oldv = {{32{oldv[31]}}, oldv[31:0]};
      b = w ? {{32{rs2[31]}}, rs2[31:0]} : rs2;
      s = oldv + b;
      case (op)
        4'd1: newv = w ? {{32{s[31]}}, s[31:0]} : s;
        4'd2: newv = oldv ^ b;
        4'd3: newv = oldv & b;
        4'd4: newv = oldv | b;
        4'd5: newv = ($signed(oldv) < $signed(b)) ? oldv : b;
        4'd6: newv = ($signed(oldv) > $signed(b)) ? oldv : b;
        4'd7: newv = (oldv < b) ? oldv : b;
        4'd8: newv = (oldv > b) ? oldv : b;
        default: newv = b;
      endcase
      we.data = '0;
      we.be = '0;
      for (int i = 0; i < nb; i++) begin
        we.data[8*(off+i) +: 8] = newv[8*i +: 8];
        we.be[off+i] = 1'b1;
        ref_mem[8*(off+i) +: 8] = newv[8*i +: 8];
      end
      wr_q.push_back(we);
      rd_q.push_back(1'b1);
    end
    re.id = id;
    re.data = err ? 64'd0 : oldv;
    re.err = err;
    resp_q.push_back(re);

    @(posedge clk); #1;
    req_valid_i = 1'b1; req_op_i = op; req_w_i = w; req_off_i = off; req_rs2_i = rs2; req_id_i = id;
    req_cyc = 0;
    done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (req_ready_o) begin
        req_cyc = cyc + 1;
        done = 1;
      end
    end
    check("req_accepted", done, 1'b1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    req_op_i = 4'($urandom); req_off_i = 4'($urandom); req_rs2_i = {$urandom, $urandom};
    req_id_i = 4'($urandom); req_w_i = 1'($urandom);
    done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (resp_q.size() == 0) done = 1;
    end
    check("resp_done", done, 1'b1);
    if (!done) begin
      wr_q.delete(); resp_q.delete(); rd_q.delete();
    end else if (fast) begin
      check("latency", 128'(resp_cyc - req_cyc), err ? 128'd1 : 128'd5);
    end
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : driver
    logic [63:0] pats [8];
    logic [3:0] op, off;
    logic w;
    logic [63:0] rs2;
    bit done;
    pats = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF, 64'h8000_0000,
             64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {rd_valid_o, wr_valid_o, resp_valid_o, resp_err_o, busy_o, req_ready_o,
           wr_be_o, resp_id_o, alu_opcode_o, alu_op_w_o},
          {6'b000001, 16'h0, 4'h0, 4'h0, 1'b0});
    check("reset_data", {wr_data_o | {64'd0, resp_data_o}}, 128'd0);
    @(posedge clk); #1 rstn = 1'b1;

    fast = 1'b1;
    // Test 1: AMOADD.D at off 8
    do_amo(4'd0, 1'b0, 4'd8, 64'd5, 4'h1);
    do_amo(4'd1, 1'b0, 4'd8, 64'd3, 4'h2);
    // Test 2: AMOADD.W overflow at off 4
    do_amo(4'd0, 1'b1, 4'd4, 64'h7FFF_FFFF, 4'h3);
    do_amo(4'd1, 1'b1, 4'd4, 64'd1, 4'h4);
    // Test 3: signed vs unsigned max on 0xFFFF_FFFF
    do_amo(4'd0, 1'b1, 4'd0, 64'hFFFF_FFFF, 4'h5);
    do_amo(4'd6, 1'b1, 4'd0, 64'd1, 4'h6);
    do_amo(4'd0, 1'b1, 4'd0, 64'hFFFF_FFFF, 4'h7);
    do_amo(4'd8, 1'b1, 4'd0, 64'd1, 4'h8);
    // Test 4: misaligned
    do_amo(4'd1, 1'b0, 4'd4, 64'd9, 4'h9);
    // Test 5: swap with backpressure everywhere
    fast = 1'b0;
    do_amo(4'd0, 1'b0, 4'd0, 64'hDEAD_BEEF_CAFE_F00D, 4'hA);
    do_amo(4'd0, 1'b0, 4'd8, 64'h1122_3344_5566_7788, 4'hB);

    // Test 6: reset while waiting for read data
    fast = 1'b1;
    rd_delay_force = 4;
    rd_q.push_back(1'b1);
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_op_i = 4'd1; req_w_i = 1'b0; req_off_i = 4'd0;
    req_rs2_i = 64'd77; req_id_i = 4'hC;
    done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (req_ready_o) begin
        @(posedge clk); #1 req_valid_i = 1'b0;
      end
      if (rd_valid_o && rd_ready_i) done = 1;
    end
    check("rst_rd_issued", done, 1'b1);
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_idle", {busy_o, req_ready_o, rd_valid_o, wr_valid_o, resp_valid_o}, 5'b01000);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rst_no_write", {wr_valid_o, resp_valid_o, busy_o}, 3'b000);
    end
    rd_delay_force = 0;
    rd_q.delete();
    do_amo(4'd4, 1'b0, 4'd0, 64'h00F0_0000_0000_0F0F, 4'hD);

    // Randomized traffic
    for (int n = 0; n < 160; n++) begin
      fast = (n % 4 == 0);
      op = ($urandom % 4 != 0) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 15));
      w = 1'($urandom);
      if ($urandom % 8 == 0) off = 4'($urandom);
      else off = w ? 4'(4 * $urandom_range(0, 3)) : 4'(8 * $urandom_range(0, 1));
      rs2 = ($urandom % 3 == 0) ? pats[$urandom_range(0, 7)] : {$urandom, $urandom};
      do_amo(op, w, off, rs2, 4'($urandom));
    end

    repeat (4) @(negedge clk);
    check("final_mem", bank_mem, ref_mem);
    check("queues_empty", 128'(wr_q.size() + resp_q.size() + rd_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
